// File: rtl/instruction_memaccess.sv
// Memory-access pipeline stage: forwards ALU results, performs one data-bus
// access per load/store, aligns/extends load data, and holds one output entry.
module instruction_memaccess #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic [31:0] t_instr,
    input  logic        t_instr_valid,
    output logic        t_instr_ready,
    input  logic [31:0] iPC,
    input  logic [4:0]  iDecodedOP,
    input  logic [31:0] iAluResult,
    input  logic [31:0] iRs2Value,
    output logic [31:0] i_instr,
    output logic        i_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] oPC,
    output logic [4:0]  oDecodedOP,
    output logic [31:0] maAlu_rdValue,
    output logic        misalign,
    output logic        dbus_valid,
    input  logic        dbus_ready,
    output logic [31:0] dbus_addr,
    output logic        dbus_we,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_rvalid
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 5;
    localparam int unsigned STRBW = 4;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, OUT} state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [OPW-1:0]      op_q, op_d;
    logic [XLEN-1:0]     ea_q, ea_d;
    logic [XLEN-1:0]     rd_q, rd_d;
    logic                mis_q, mis_d;
    logic                ivalid_q, ivalid_d;
    logic                dvalid_q, dvalid_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                we_q, we_d;
    logic [STRBW-1:0]    wstrb_q, wstrb_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;

    logic       accept;
    logic       in_load, in_store, in_mis;
    logic [2:0] in_f3;
    logic [1:0] in_lane;

    // Align and extend the addressed byte/half of a returned word.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rdata >> {lane, 3'b000});
        h = 16'(rdata >> {lane[1], 4'b0000});
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'b0, b};
            3'b101:  load_extend = {16'b0, h};
            default: load_extend = rdata;
        endcase
    endfunction

    // Byte accesses never misalign; undefined funct3 behaves as a word access.
    function automatic logic is_misaligned(input logic is_ld, input logic [2:0] f3,
                                           input logic [1:0] lane);
        if (is_ld) begin
            case (f3)
                3'b000, 3'b100: is_misaligned = 1'b0;
                3'b001, 3'b101: is_misaligned = lane[0];
                default:        is_misaligned = |lane;
            endcase
        end else begin
            case (f3)
                3'b000:  is_misaligned = 1'b0;
                3'b001:  is_misaligned = lane[0];
                default: is_misaligned = |lane;
            endcase
        end
    endfunction

    function automatic logic [STRBW-1:0] store_strb(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            3'b000:  store_strb = 4'(4'b0001 << lane);
            3'b001:  store_strb = 4'(4'b0011 << {lane[1], 1'b0});
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [XLEN-1:0] rs2);
        case (f3)
            3'b000:  store_data = {4{rs2[7:0]}};
            3'b001:  store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    assign t_instr_ready = (state_q == IDLE) | ((state_q == OUT) & i_instr_ready);
    assign accept        = t_instr_valid & t_instr_ready;
    assign in_load       = (t_instr[6:0] == OPC_LOAD);
    assign in_store      = (t_instr[6:0] == OPC_STORE);
    assign in_f3         = t_instr[14:12];
    assign in_lane       = iAluResult[1:0];
    assign in_mis        = MISALIGN_CHECK & is_misaligned(in_load, in_f3, in_lane);

    // Next-state and next-output logic; a new accept overrides the state step.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        op_d     = op_q;
        ea_d     = ea_q;
        rd_d     = rd_q;
        mis_d    = mis_q;
        ivalid_d = ivalid_q;
        dvalid_d = dvalid_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;

        case (state_q)
            REQ: begin
                if (dbus_ready) begin
                    dvalid_d = 1'b0;
                    we_d     = 1'b0;
                    wstrb_d  = '0;
                    if (instr_q[6:0] == OPC_STORE) begin
                        rd_d     = ea_q;
                        ivalid_d = 1'b1;
                        state_d  = OUT;
                    end else if (dbus_rvalid) begin
                        rd_d     = load_extend(dbus_rdata, instr_q[14:12], ea_q[1:0]);
                        ivalid_d = 1'b1;
                        state_d  = OUT;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (dbus_rvalid) begin
                    rd_d     = load_extend(dbus_rdata, instr_q[14:12], ea_q[1:0]);
                    ivalid_d = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (i_instr_ready) begin
                    ivalid_d = 1'b0;
                    mis_d    = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            instr_d = t_instr;
            pc_d    = iPC;
            op_d    = iDecodedOP;
            ea_d    = iAluResult;
            mis_d   = 1'b0;
            if (in_load | in_store) begin
                if (in_mis) begin
                    mis_d    = 1'b1;
                    rd_d     = '0;
                    ivalid_d = 1'b1;
                    state_d  = OUT;
                end else begin
                    ivalid_d = 1'b0;
                    dvalid_d = 1'b1;
                    addr_d   = {iAluResult[31:2], 2'b00};
                    we_d     = in_store;
                    wstrb_d  = in_store ? store_strb(in_f3, in_lane) : '0;
                    if (in_store) begin
                        wdata_d = store_data(in_f3, iRs2Value);
                    end
                    state_d = REQ;
                end
            end else begin
                rd_d     = iAluResult;
                ivalid_d = 1'b1;
                state_d  = OUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstf) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            op_q     <= '0;
            ea_q     <= '0;
            rd_q     <= '0;
            mis_q    <= 1'b0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            ea_q     <= ea_d;
            rd_q     <= rd_d;
            mis_q    <= mis_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
        end
    end

    assign i_instr       = instr_q;
    assign i_instr_valid = ivalid_q;
    assign oPC           = pc_q;
    assign oDecodedOP    = op_q;
    assign maAlu_rdValue = rd_q;
    assign misalign      = mis_q;
    assign dbus_valid    = dvalid_q;
    assign dbus_addr     = addr_q;
    assign dbus_we       = we_q;
    assign dbus_wstrb    = wstrb_q;
    assign dbus_wdata    = wdata_q;

endmodule

// File: tb/tb_instruction_memaccess.sv
// Scoreboard bench for instruction_memaccess: directed vectors, an output
// monitor and a bus monitor compare against queued expectations.
module tb_instruction_memaccess;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] rd;
        logic        mis;
    } out_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] t_instr;
    logic        t_instr_valid;
    logic        t_instr_ready;
    logic [31:0] iPC;
    logic [4:0]  iDecodedOP;
    logic [31:0] iAluResult;
    logic [31:0] iRs2Value;
    logic [31:0] i_instr;
    logic        i_instr_valid;
    logic        i_instr_ready;
    logic [31:0] oPC;
    logic [4:0]  oDecodedOP;
    logic [31:0] maAlu_rdValue;
    logic        misalign;
    logic        dbus_valid;
    logic        dbus_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_rvalid;

    // Second instance with the alignment check disabled; shares upstream data.
    logic        nc_tvalid, nc_tready, nc_ivalid, nc_mis, nc_dvalid, nc_we;
    logic [31:0] nc_instr, nc_pc, nc_rd, nc_addr, nc_wdata, nc_rdata;
    logic [4:0]  nc_op;
    logic [3:0]  nc_wstrb;
    logic        nc_dready, nc_rvalid;

    int n_checks = 0;
    int n_fail   = 0;
    int bus_cycles = 0;
    int ready_dly = 0;
    int rv_dly    = 0;
    logic [31:0] rd_cfg = '0;

    out_exp_t out_q[$];
    bus_exp_t bus_q[$];

    always #5 clk = ~clk;

    instruction_memaccess #(.MISALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rstf(rstf),
        .t_instr(t_instr), .t_instr_valid(t_instr_valid), .t_instr_ready(t_instr_ready),
        .iPC(iPC), .iDecodedOP(iDecodedOP), .iAluResult(iAluResult), .iRs2Value(iRs2Value),
        .i_instr(i_instr), .i_instr_valid(i_instr_valid), .i_instr_ready(i_instr_ready),
        .oPC(oPC), .oDecodedOP(oDecodedOP), .maAlu_rdValue(maAlu_rdValue), .misalign(misalign),
        .dbus_valid(dbus_valid), .dbus_ready(dbus_ready), .dbus_addr(dbus_addr),
        .dbus_we(dbus_we), .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_rvalid(dbus_rvalid)
    );

    instruction_memaccess #(.MISALIGN_CHECK(1'b0)) dut_nc (
        .clk(clk), .rstf(rstf),
        .t_instr(t_instr), .t_instr_valid(nc_tvalid), .t_instr_ready(nc_tready),
        .iPC(iPC), .iDecodedOP(iDecodedOP), .iAluResult(iAluResult), .iRs2Value(iRs2Value),
        .i_instr(nc_instr), .i_instr_valid(nc_ivalid), .i_instr_ready(i_instr_ready),
        .oPC(nc_pc), .oDecodedOP(nc_op), .maAlu_rdValue(nc_rd), .misalign(nc_mis),
        .dbus_valid(nc_dvalid), .dbus_ready(nc_dready), .dbus_addr(nc_addr),
        .dbus_we(nc_we), .dbus_wstrb(nc_wstrb), .dbus_wdata(nc_wdata),
        .dbus_rdata(nc_rdata), .dbus_rvalid(nc_rvalid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: pop and compare on every downstream handshake.
    always @(negedge clk) begin
        if (rstf && i_instr_valid && i_instr_ready) begin
            if (out_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                out_exp_t e;
                e = out_q.pop_front();
                chk("out_instr", i_instr, e.instr);
                chk("out_pc", oPC, e.pc);
                chk("out_op", 32'(oDecodedOP), 32'(e.op));
                chk("out_rd", maAlu_rdValue, e.rd);
                chk("out_misalign", 32'(misalign), 32'(e.mis));
            end
        end
    end

    // Bus monitor: pop and compare on every bus request handshake.
    always @(negedge clk) begin
        if (dbus_valid) bus_cycles++;
        if (rstf && dbus_valid && dbus_ready) begin
            if (bus_q.size() == 0) begin
                chk("unexpected_bus", 32'd1, 32'd0);
            end else begin
                bus_exp_t b;
                b = bus_q.pop_front();
                chk("bus_addr", dbus_addr, b.addr);
                chk("bus_we", 32'(dbus_we), 32'(b.we));
                if (b.we) begin
                    chk("bus_wstrb", 32'(dbus_wstrb), 32'(b.wstrb));
                    chk("bus_wdata", dbus_wdata, b.wdata);
                end
            end
        end
    end

    // Bus slave: ready after ready_dly cycles, read data rv_dly cycles after ready.
    always begin
        logic is_st;
        @(posedge clk); #1;
        if (rstf && dbus_valid) begin
            is_st = dbus_we;
            repeat (ready_dly) begin @(posedge clk); #1; end
            dbus_ready = 1'b1;
            if (!is_st && rv_dly == 0) begin
                dbus_rvalid = 1'b1;
                dbus_rdata  = rd_cfg;
            end
            @(posedge clk); #1;
            dbus_ready  = 1'b0;
            dbus_rvalid = 1'b0;
            dbus_rdata  = '0;
            if (!is_st && rv_dly > 0) begin
                repeat (rv_dly - 1) begin @(posedge clk); #1; end
                dbus_rvalid = 1'b1;
                dbus_rdata  = rd_cfg;
                @(posedge clk); #1;
                dbus_rvalid = 1'b0;
                dbus_rdata  = '0;
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] op,
                         input logic [31:0] alu, input logic [31:0] rs2);
        t_instr    = ins;
        iPC        = pc;
        iDecodedOP = op;
        iAluResult = alu;
        iRs2Value  = rs2;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] op,
                        input logic [31:0] alu, input logic [31:0] rs2);
        bit ok;
        drive(ins, pc, op, alu, rs2);
        t_instr_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (t_instr_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        t_instr_valid = 1'b0;
    endtask

    task automatic push_out(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] op,
                            input logic [31:0] rd, input logic mis);
        out_exp_t e;
        e.instr = ins; e.pc = pc; e.op = op; e.rd = rd; e.mis = mis;
        out_q.push_back(e);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                            input logic [31:0] wd);
        bus_exp_t b;
        b.addr = addr; b.we = we; b.wstrb = strb; b.wdata = wd;
        bus_q.push_back(b);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_q.size() == 0 && bus_q.size() == 0 && !i_instr_valid) begin
                ok = 1'b1; break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_hs();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (dbus_valid && dbus_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("bus_hs_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int seen;
        rstf = 1'b0;
        t_instr_valid = 1'b0; i_instr_ready = 1'b1;
        nc_tvalid = 1'b0; nc_dready = 1'b0; nc_rvalid = 1'b0; nc_rdata = '0;
        dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        drive('0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rstf = 1'b1;
        @(negedge clk);
        chk("rst_ivalid", 32'(i_instr_valid), 32'd0);
        chk("rst_dvalid", 32'(dbus_valid), 32'd0);
        chk("rst_rd", maAlu_rdValue, 32'd0);
        chk("rst_wstrb", 32'(dbus_wstrb), 32'd0);
        chk("rst_tready", 32'(t_instr_ready), 32'd1);
        @(posedge clk); #1;

        // Single ALU op: one-cycle latency
        push_out(32'h00B50533, 32'h100, 5'd3, 32'h1234, 1'b0);
        send(32'h00B50533, 32'h100, 5'd3, 32'h1234, 32'h0);
        @(negedge clk);
        chk("alu_lat_valid", 32'(i_instr_valid), 32'd1);
        chk("alu_lat_rd", maAlu_rdValue, 32'h1234);
        drain();

        // Back-to-back ALU stream at one per cycle
        for (int i = 0; i < 3; i++) begin
            drive(32'h00B50533 + 32'(i << 7), 32'h200 + 32'(4 * i), 5'(i + 1),
                  32'hA000 + 32'(i), 32'h0);
            push_out(32'h00B50533 + 32'(i << 7), 32'h200 + 32'(4 * i), 5'(i + 1),
                     32'hA000 + 32'(i), 1'b0);
            t_instr_valid = 1'b1;
            @(negedge clk);
            chk("stream_tready", 32'(t_instr_ready), 32'd1);
            @(posedge clk); #1;
        end
        t_instr_valid = 1'b0;
        drain();

        // LB / LBU at lane 3, delayed ready and read data
        ready_dly = 2; rv_dly = 3; rd_cfg = 32'h80FFFFFF;
        push_bus(32'h1000, 1'b0, 4'b0, 32'h0);
        push_out(32'h00050583, 32'h300, 5'd8, 32'hFFFFFF80, 1'b0);
        send(32'h00050583, 32'h300, 5'd8, 32'h1003, 32'h0);
        drain();
        push_bus(32'h1000, 1'b0, 4'b0, 32'h0);
        push_out(32'h00054583, 32'h304, 5'd9, 32'h00000080, 1'b0);
        send(32'h00054583, 32'h304, 5'd9, 32'h1003, 32'h0);
        drain();

        // SH at lane 2, immediate ready; output one cycle after handshake
        ready_dly = 0; rv_dly = 0;
        push_bus(32'h2000, 1'b1, 4'b1100, 32'h56785678);
        push_out(32'h00B51023, 32'h400, 5'd10, 32'h2002, 1'b0);
        send(32'h00B51023, 32'h400, 5'd10, 32'h2002, 32'hAAAA5678);
        wait_hs();
        @(negedge clk);
        chk("sh_out_lat", 32'(i_instr_valid), 32'd1);
        drain();

        // Misaligned LW: no bus access
        c0 = bus_cycles;
        push_out(32'h00052583, 32'h500, 5'd11, 32'h0, 1'b1);
        send(32'h00052583, 32'h500, 5'd11, 32'h3001, 32'h0);
        drain();
        chk("mis_no_bus", 32'(bus_cycles - c0), 32'd0);

        // Misaligned LW with the check disabled goes to the word
        drive(32'h00052583, 32'h600, 5'd12, 32'h3001, 32'h0);
        nc_tvalid = 1'b1;
        @(posedge clk); #1;
        nc_tvalid = 1'b0;
        @(negedge clk);
        chk("nc_dvalid", 32'(nc_dvalid), 32'd1);
        chk("nc_addr", nc_addr, 32'h3000);
        chk("nc_we", 32'(nc_we), 32'd0);
        @(posedge clk); #1;
        nc_dready = 1'b1; nc_rvalid = 1'b1; nc_rdata = 32'h11223344;
        @(posedge clk); #1;
        nc_dready = 1'b0; nc_rvalid = 1'b0; nc_rdata = '0;
        @(negedge clk);
        chk("nc_ivalid", 32'(nc_ivalid), 32'd1);
        chk("nc_rd", nc_rd, 32'h11223344);
        chk("nc_mis", 32'(nc_mis), 32'd0);
        @(posedge clk); #1;

        // LW with ready and rvalid together, then downstream stall
        rd_cfg = 32'hDEADBEEF;
        i_instr_ready = 1'b0;
        push_bus(32'h4000, 1'b0, 4'b0, 32'h0);
        push_out(32'h00052583, 32'h700, 5'd13, 32'hDEADBEEF, 1'b0);
        send(32'h00052583, 32'h700, 5'd13, 32'h4000, 32'h0);
        wait_hs();
        @(negedge clk);
        chk("lw_direct_out", 32'(i_instr_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(i_instr_valid), 32'd1);
            chk("stall_rd", maAlu_rdValue, 32'hDEADBEEF);
            chk("stall_pc", oPC, 32'h700);
            chk("stall_tready", 32'(t_instr_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_instr_ready = 1'b1;
        drain();

        // Reset while waiting for read data; late rvalid must be ignored
        ready_dly = 1; rv_dly = 3; rd_cfg = 32'h12345678;
        push_bus(32'h5000, 1'b0, 4'b0, 32'h0);
        send(32'h00052583, 32'h800, 5'd14, 32'h5000, 32'h0);
        wait_hs();
        @(posedge clk); #1;
        rstf = 1'b0;
        @(posedge clk); #1;
        rstf = 1'b1;
        @(negedge clk);
        chk("mid_rst_ivalid", 32'(i_instr_valid), 32'd0);
        chk("mid_rst_dvalid", 32'(dbus_valid), 32'd0);
        chk("mid_rst_rd", maAlu_rdValue, 32'd0);
        chk("mid_rst_instr", i_instr, 32'd0);
        chk("mid_rst_pc", oPC, 32'd0);
        chk("mid_rst_addr", dbus_addr, 32'd0);
        chk("mid_rst_wdata", dbus_wdata, 32'd0);
        chk("mid_rst_tready", 32'(t_instr_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i_instr_valid) seen++;
        end
        chk("late_rvalid_ignored", 32'(seen), 32'd0);
        @(posedge clk); #1;
        push_out(32'h00C50633, 32'h900, 5'd15, 32'h5555, 1'b0);
        send(32'h00C50633, 32'h900, 5'd15, 32'h5555, 32'h0);
        drain();

        chk("queues_empty", 32'(out_q.size() + bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
